// File: rtl/fdiv_newton_core.sv
// Newton-Raphson mantissa divider: a/d via reciprocal iteration X <= X*(2 - D*X),
// time-sharing a single 26x26 multiplier across all steps.

module wallace_26x26_product (
    input  logic [25:0] i_a,
    input  logic [25:0] i_b,
    output logic [51:0] o_p
);

    logic [51:0] w_sum;
    logic [51:0] w_car;
    logic [51:0] w_pp;
    logic [51:0] w_tmp;

    // Carry-save reduction of the partial products, one carry-propagate add at the end
    always_comb begin
        w_sum = 52'd0;
        w_car = 52'd0;
        w_pp  = 52'd0;
        w_tmp = 52'd0;
        for (int i = 0; i < 26; i++) begin
            if (i_b[i]) begin
                w_pp = 52'(i_a) << i;
            end else begin
                w_pp = 52'd0;
            end
            w_tmp = w_sum ^ w_car ^ w_pp;
            w_car = ((w_sum & w_car) | (w_sum & w_pp) | (w_car & w_pp)) << 1;
            w_sum = w_tmp;
        end
        o_p = w_sum + w_car;
    end

endmodule

module fdiv_newton_core #(
    parameter int ITERS = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [23:0] a,
    input  logic [23:0] d,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [51:0] q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_DX = 2'd1,
        MUL_XT = 2'd2,
        FINAL  = 2'd3
    } state_t;

    localparam logic [1:0] ITERS_W = 2'(ITERS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_inc;
    logic [25:0] r_x;
    logic [25:0] r_t;
    logic [25:0] r_d;
    logic [25:0] r_a;
    logic [51:0] r_q;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [25:0] w_op_a;
    logic [25:0] w_op_b;
    logic [51:0] w_z;

    // Seed reciprocal: floor(4096/(33+2i)) is 1/d at the midpoint of each 1/16 interval
    function automatic logic [7:0] x0_lut(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd0:    v = 8'd124;
            4'd1:    v = 8'd117;
            4'd2:    v = 8'd110;
            4'd3:    v = 8'd105;
            4'd4:    v = 8'd99;
            4'd5:    v = 8'd95;
            4'd6:    v = 8'd91;
            4'd7:    v = 8'd87;
            4'd8:    v = 8'd83;
            4'd9:    v = 8'd80;
            4'd10:   v = 8'd77;
            4'd11:   v = 8'd74;
            4'd12:   v = 8'd71;
            4'd13:   v = 8'd69;
            4'd14:   v = 8'd67;
            4'd15:   v = 8'd65;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    assign w_cnt_inc = r_cnt + 2'd1;

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && d[23]) begin
                    w_state_nxt = MUL_DX;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            MUL_DX: w_state_nxt = MUL_XT;
            MUL_XT: begin
                if (w_cnt_inc < ITERS_W) begin
                    w_state_nxt = MUL_DX;
                end else begin
                    w_state_nxt = FINAL;
                end
            end
            FINAL:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Multiplier operand selection for the shared product
    always_comb begin
        w_op_a = 26'd0;
        w_op_b = 26'd0;
        case (r_state)
            MUL_DX: begin
                w_op_a = r_d;
                w_op_b = r_x;
            end
            MUL_XT: begin
                w_op_a = r_x;
                w_op_b = r_t;
            end
            FINAL: begin
                w_op_a = r_a;
                w_op_b = r_x;
            end
            default: begin
                w_op_a = 26'd0;
                w_op_b = 26'd0;
            end
        endcase
    end

    wallace_26x26_product u_mul (
        .i_a (w_op_a),
        .i_b (w_op_b),
        .o_p (w_z)
    );

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt  <= 2'd0;
            r_x    <= 26'd0;
            r_t    <= 26'd0;
            r_d    <= 26'd0;
            r_a    <= 26'd0;
            r_q    <= 52'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_state_nxt != IDLE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (d[23]) begin
                            r_d   <= {d, 2'b00};
                            r_a   <= {a, 2'b00};
                            r_x   <= {x0_lut(d[22:19]), 18'd0};
                            r_cnt <= 2'd0;
                            r_err <= 1'b0;
                        end else begin
                            r_q    <= 52'd0;
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end
                    end
                end
                // T = 2 - D*X, taken modulo 2 in 1.25 format
                MUL_DX: r_t <= 26'd0 - w_z[50:25];
                MUL_XT: begin
                    r_x   <= w_z[50:25];
                    r_cnt <= w_cnt_inc;
                end
                FINAL: begin
                    r_q    <= w_z;
                    r_done <= 1'b1;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
    assign q    = r_q;

endmodule

// File: tb/tb_fdiv_newton_core.sv
// Randomized bench for fdiv_newton_core: quotients are checked against an exact
// integer division floor(a*2^50/d), plus latency, busy, err and reset behaviour.

module tb_fdiv_newton_core;

    logic        clk;
    logic        clrn;
    logic        start;
    logic [23:0] a;
    logic [23:0] d;
    logic        busy;
    logic        done;
    logic        err;
    logic [51:0] q;

    int n_vec;
    int n_err;

    localparam longint QTOL = (longint'(1) << 28) - 2;

    fdiv_newton_core dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .a     (a),
        .d     (d),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .q     (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
        longint diff;
        n_vec++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic logic [23:0] rand_norm();
        return {1'b1, 23'($urandom)};
    endfunction

    // Issue one request (caller is just after a clock edge) and wait for its done pulse
    task automatic run_op(input logic [23:0] ta, input logic [23:0] td, input bit poke);
        int          n;
        int          nb;
        bit          bad;
        logic [127:0] num;
        longint      qexp;
        bad   = (td[23] == 1'b0);
        a     = ta;
        d     = td;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = 24'($urandom);
        d     = 24'($urandom);
        n  = 0;
        nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            if (poke && n == 3) start = 1'b1;
            else start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("done", longint'(done), 1, 0);
        chk("latency", longint'(n), bad ? 0 : 7, 0);
        chk("busy_cycles", longint'(nb), bad ? 0 : 7, 0);
        chk("busy_at_done", longint'(busy), 0, 0);
        chk("err", longint'(err), bad ? 1 : 0, 0);
        if (bad) begin
            chk("q_on_err", longint'(q), 0, 0);
        end else begin
            num  = 128'(ta) << 50;
            num  = num / 128'(td);
            qexp = longint'(num[63:0]);
            chk("quotient", longint'(q), qexp, QTOL);
        end
    endtask

    // Finish a non-back-to-back op: done must drop after one cycle
    task automatic settle();
        @(posedge clk); #1;
        chk("done_width", longint'(done), 0, 0);
    endtask

    initial begin
        int ndone;
        n_vec = 0;
        n_err = 0;
        clrn  = 1'b0;
        start = 1'b0;
        a     = 24'd0;
        d     = 24'd0;
        #13;
        chk("rst_busy", longint'(busy), 0, 0);
        chk("rst_done", longint'(done), 0, 0);
        chk("rst_err", longint'(err), 0, 0);
        chk("rst_q", longint'(q), 0, 0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk); #1;

        // Directed operand pairs
        run_op(24'h800000, 24'h800000, 1'b0);
        chk("one_over_one", longint'(q[51:25]), longint'(1) << 25, 4);
        settle();
        run_op(24'hC00000, 24'h800000, 1'b0);
        chk("one_point_five", longint'(q[51:25]), 64'h3000000, 4);
        settle();
        run_op(24'hC00000, 24'hC00000, 1'b0);
        chk("c_over_c", longint'(q[51:25]), longint'(1) << 25, 4);
        settle();
        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b0);
        chk("max_over_max", longint'(q[51:25]), longint'(1) << 25, 4);
        settle();

        // Unnormalized divisor, then a valid op clears err
        run_op(24'h123456, 24'h400000, 1'b0);
        settle();
        run_op(rand_norm(), rand_norm(), 1'b0);
        settle();

        // Back-to-back: start issued in each done cycle, one start while busy
        for (int k = 0; k < 4; k++) begin
            run_op(rand_norm(), rand_norm(), k == 1);
        end
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("no_extra_done", longint'(ndone), 0, 0);

        // Random sweep with occasional bad divisors
        for (int k = 0; k < 24; k++) begin
            if (k % 8 == 5) run_op(rand_norm(), {1'b0, 23'($urandom)}, 1'b0);
            else run_op(rand_norm(), rand_norm(), 1'b0);
            settle();
        end

        // Asynchronous reset in MUL_XT aborts the operation
        run_op(24'hA00000, 24'h900000, 1'b0);
        settle();
        a     = rand_norm();
        d     = rand_norm();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        clrn = 1'b0;
        #1;
        chk("abort_busy", longint'(busy), 0, 0);
        chk("abort_done", longint'(done), 0, 0);
        chk("abort_q", longint'(q), 0, 0);
        chk("abort_err", longint'(err), 0, 0);
        #1;
        clrn  = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("no_done_after_abort", longint'(ndone), 0, 0);
        run_op(rand_norm(), rand_norm(), 1'b0);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
